// File: rtl/fc_pkg.sv
// Shared definitions for the FC column sequencer.
//   state_t     : sequencer FSM states
//   FP_ZERO     : IEEE-754 single +0.0, driven into the PE when it must hold
//   FP_SIGN_BIT : sign bit position of an IEEE-754 single word
package fc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      MAC     = 3'd2,
      CAPTURE = 3'd3,
      OUT     = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
   localparam int          FP_SIGN_BIT = 31;

endpackage

// File: rtl/fc_addr_gen.sv
// Term/column counters and buffer read addresses for the FC sequencer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   run_start   : new run accepted; col=0, k=0, addresses point at term 0
//   clear_step  : sequencer is in CLEAR; advance addresses to term 1
//   mac_step    : sequencer is in MAC; k advances, addresses run one term ahead
//   next_col    : output handshake on a non-final column; col++, rewind k
//   in_addr     : input buffer read address (term index)
//   w_addr      : weight buffer read address, col*N_IN + term, modulo 2**W_AW
//   col         : current column
//   last_k      : k is the final term of the column
//   last_col    : col is the final column of the run
module fc_addr_gen #(
   parameter int N_IN   = 16,
   parameter int N_OUT  = 8,
   parameter int IN_AW  = 4,
   parameter int W_AW   = 7,
   parameter int OUT_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_start,
   input  logic              clear_step,
   input  logic              mac_step,
   input  logic              next_col,
   output logic [IN_AW-1:0]  in_addr,
   output logic [W_AW-1:0]   w_addr,
   output logic [OUT_AW-1:0] col,
   output logic              last_k,
   output logic              last_col
);

   logic [IN_AW-1:0]  k;
   logic [OUT_AW-1:0] col_nxt;
   logic [W_AW-1:0]   w_base_nxt;
   logic              adv_addr;

   // The memories have one cycle of read latency, so while term k is on the
   // data buses the address registers already hold term k+1. The address
   // stops moving once the final term has been issued, which also keeps it
   // frozen through CAPTURE and any OUT stall.
   always_comb begin
      col_nxt    = col + 1'b1;
      w_base_nxt = W_AW'(32'(col_nxt) * 32'(N_IN));
      last_k     = (32'(k) == 32'(N_IN - 1));
      last_col   = (32'(col) == 32'(N_OUT - 1));
      adv_addr   = (clear_step && (N_IN > 1)) ||
                   (mac_step && ((32'(k) + 32'd2) < 32'(N_IN)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k       <= '0;
         col     <= '0;
         in_addr <= '0;
         w_addr  <= '0;
      end else if (run_start) begin
         k       <= '0;
         col     <= '0;
         in_addr <= '0;
         w_addr  <= '0;
      end else if (next_col) begin
         k       <= '0;
         col     <= col_nxt;
         in_addr <= '0;
         w_addr  <= w_base_nxt;
      end else begin
         if (mac_step && !last_k) begin
            k <= k + 1'b1;
         end
         if (adv_addr) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fc_col_sequencer.sv
// Upstream sequencer and result collector for one FC processing element.
// For each output column it clears the PE accumulator, streams N_IN
// input/weight pairs from synchronous-read buffers into the PE, captures the
// dot product (optionally through ReLU) and hands it downstream.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, relu_en   : run request (IDLE only) and ReLU enable latched with it
//   busy, done       : run in progress / one-cycle completion pulse
//   in_addr, in_data : input buffer read port (1-cycle latency)
//   w_addr, w_data   : weight buffer read port (1-cycle latency)
//   pe_input, pe_weight, pe_start_newcol : drive to the PE
//   pe_result        : PE accumulator output
//   out_valid, out_ready, out_data, out_index : result stream
// Handshake: out_valid rises with a result and holds, with out_data and
// out_index stable, until the cycle in which out_ready is also high; the
// transfer happens on that clock edge. out_ready without out_valid is ignored.
module fc_col_sequencer
   import fc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_IN       = 16,
   parameter int N_OUT      = 8,
   parameter int IN_AW      = 4,
   parameter int W_AW       = 7,
   parameter int OUT_AW     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  relu_en,
   output logic                  busy,
   output logic                  done,
   output logic [IN_AW-1:0]      in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [W_AW-1:0]       w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic [DATA_WIDTH-1:0] pe_input,
   output logic [DATA_WIDTH-1:0] pe_weight,
   output logic                  pe_start_newcol,
   input  logic [DATA_WIDTH-1:0] pe_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [OUT_AW-1:0]     out_index
);

   if (DATA_WIDTH != 32) begin : g_chk_dw
      $error("fc_col_sequencer: DATA_WIDTH must be 32 (IEEE-754 single)");
   end
   if ((N_IN < 1) || (N_OUT < 1)) begin : g_chk_n
      $error("fc_col_sequencer: N_IN and N_OUT must be >= 1");
   end
   if ((2 ** IN_AW) < N_IN) begin : g_chk_in_aw
      $error("fc_col_sequencer: IN_AW too small for N_IN");
   end
   if ((2 ** W_AW) < (N_IN * N_OUT)) begin : g_chk_w_aw
      $error("fc_col_sequencer: W_AW too small for N_IN*N_OUT");
   end
   if ((2 ** OUT_AW) < N_OUT) begin : g_chk_out_aw
      $error("fc_col_sequencer: OUT_AW too small for N_OUT");
   end

   state_t            state;
   logic              relu_q;
   logic [OUT_AW-1:0] col;
   logic              last_k;
   logic              last_col;
   logic              run_start;
   logic              clear_step;
   logic              mac_step;
   logic              handshake;
   logic              next_col;

   always_comb begin
      run_start  = (state == IDLE) && start;
      clear_step = (state == CLEAR);
      mac_step   = (state == MAC);
      handshake  = (state == OUT) && out_ready;
      next_col   = handshake && !last_col;
   end

   fc_addr_gen #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .IN_AW  (IN_AW),
      .W_AW   (W_AW),
      .OUT_AW (OUT_AW)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_start  (run_start),
      .clear_step (clear_step),
      .mac_step   (mac_step),
      .next_col   (next_col),
      .in_addr    (in_addr),
      .w_addr     (w_addr),
      .col        (col),
      .last_k     (last_k),
      .last_col   (last_col)
   );

   // Outside MAC the PE is fed +0 * +0, so its accumulator keeps its value
   // through CAPTURE, OUT stalls and IDLE.
   always_comb begin
      pe_input  = (state == MAC) ? in_data : FP_ZERO;
      pe_weight = (state == MAC) ? w_data  : FP_ZERO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         relu_q          <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pe_start_newcol <= 1'b0;
         out_valid       <= 1'b0;
         out_data        <= FP_ZERO;
         out_index       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  relu_q          <= relu_en;
                  busy            <= 1'b1;
                  pe_start_newcol <= 1'b1;
                  state           <= CLEAR;
               end
            end
            CLEAR: begin
               pe_start_newcol <= 1'b0;
               state           <= MAC;
            end
            MAC: begin
               if (last_k) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               // Any word with the sign bit set clamps to +0 under ReLU,
               // including -0 and negative NaN.
               if (relu_q && pe_result[FP_SIGN_BIT]) begin
                  out_data <= FP_ZERO;
               end else begin
                  out_data <= pe_result;
               end
               out_index <= col;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last_col) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     pe_start_newcol <= 1'b1;
                     state           <= CLEAR;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_col_sequencer.sv
// Bench for fc_col_sequencer with N_IN=4, N_OUT=2, behavioural sync-read
// buffers and a behavioural multiply-accumulate PE model.
module tb_fc_col_sequencer;

   localparam int DW     = 32;
   localparam int N_IN   = 4;
   localparam int N_OUT  = 2;
   localparam int IN_AW  = 2;
   localparam int W_AW   = 3;
   localparam int OUT_AW = 1;

   localparam logic [31:0] F_0   = 32'h0000_0000;
   localparam logic [31:0] F_05  = 32'h3F00_0000;
   localparam logic [31:0] F_1   = 32'h3F80_0000;
   localparam logic [31:0] F_M1  = 32'hBF80_0000;
   localparam logic [31:0] F_2   = 32'h4000_0000;
   localparam logic [31:0] F_3   = 32'h4040_0000;
   localparam logic [31:0] F_4   = 32'h4080_0000;
   localparam logic [31:0] F_5   = 32'h40A0_0000;
   localparam logic [31:0] F_M4  = 32'hC080_0000;
   localparam logic [31:0] F_40  = 32'h4220_0000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              relu_en = 1'b0;
   logic              busy;
   logic              done;
   logic [IN_AW-1:0]  in_addr;
   logic [DW-1:0]     in_data;
   logic [W_AW-1:0]   w_addr;
   logic [DW-1:0]     w_data;
   logic [DW-1:0]     pe_input;
   logic [DW-1:0]     pe_weight;
   logic              pe_start_newcol;
   logic [DW-1:0]     pe_result;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DW-1:0]     out_data;
   logic [OUT_AW-1:0] out_index;

   int errors = 0;
   int checks = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   fc_col_sequencer #(
      .DATA_WIDTH (DW),
      .N_IN       (N_IN),
      .N_OUT      (N_OUT),
      .IN_AW      (IN_AW),
      .W_AW       (W_AW),
      .OUT_AW     (OUT_AW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .relu_en         (relu_en),
      .busy            (busy),
      .done            (done),
      .in_addr         (in_addr),
      .in_data         (in_data),
      .w_addr          (w_addr),
      .w_data          (w_data),
      .pe_input        (pe_input),
      .pe_weight       (pe_weight),
      .pe_start_newcol (pe_start_newcol),
      .pe_result       (pe_result),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_index       (out_index)
   );

   // ---------------- buffers and PE model ----------------
   logic [DW-1:0] in_mem [0:N_IN-1];
   logic [DW-1:0] w_mem  [0:N_IN*N_OUT-1];
   logic [DW-1:0] acc = 32'h0;

   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
   end

   function automatic real sp_to_real(input logic [31:0] b);
      real r;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      r = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else       for (int i = 0; i < -e; i++) r = r / 2.0;
      return b[31] ? -r : r;
   endfunction

   function automatic logic [31:0] real_to_sp(input real x);
      logic        s;
      int          e;
      real         r;
      logic [22:0] m;
      if (x == 0.0) return 32'h0;
      s = (x < 0.0);
      r = s ? -x : x;
      e = 127;
      while (r >= 2.0) begin r = r / 2.0; e++; end
      while (r < 1.0)  begin r = r * 2.0; e--; end
      m = 23'($rtoi((r - 1.0) * 8388608.0));
      return {s, 8'(e), m};
   endfunction

   always @(posedge clk) begin
      if (pe_start_newcol) acc <= 32'h0;
      else acc <= real_to_sp(sp_to_real(acc) + sp_to_real(pe_input) * sp_to_real(pe_weight));
   end
   assign pe_result = acc;

   // ---------------- driver tasks ----------------
   logic [DW-1:0]     got_d [0:1];
   logic [OUT_AW-1:0] got_i [0:1];
   int                got_n;
   int                done_cnt;
   int                done_at;
   logic              snap_busy   [0:63];
   logic              snap_newcol [0:63];
   logic              snap_valid  [0:63];
   logic [IN_AW-1:0]  snap_in     [0:63];
   logic [W_AW-1:0]   snap_w      [0:63];

   task automatic load_mems(input logic [31:0] iv [0:3], input logic [31:0] wv [0:7]);
      for (int i = 0; i < N_IN; i++) in_mem[i] = iv[i];
      for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = wv[i];
   endtask

   task automatic load_uniform(input logic [31:0] iv, input logic [31:0] wv);
      for (int i = 0; i < N_IN; i++) in_mem[i] = iv;
      for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = wv;
   endtask

   // Starts a run and records per-cycle snapshots; index c holds the values
   // seen in the c-th cycle after the edge that accepted start.
   task automatic run_collect(input logic relu, input int pulse_at, input int ncyc);
      got_n = 0; done_cnt = 0; done_at = -1;
      got_d[0] = 'x; got_d[1] = 'x; got_i[0] = 'x; got_i[1] = 'x;
      @(negedge clk);
      start = 1'b1; relu_en = relu;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = (c == pulse_at);
         snap_busy[c] = busy; snap_newcol[c] = pe_start_newcol; snap_valid[c] = out_valid;
         snap_in[c] = in_addr; snap_w[c] = w_addr;
         if (out_valid && out_ready && got_n < 2) begin
            got_d[got_n] = out_data; got_i[got_n] = out_index; got_n++;
         end
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
      end
      start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
      checks++; if (pe_start_newcol !== 1'b0) begin errors++; $display("FAIL reset_newcol: got %b exp 0", pe_start_newcol); end
      checks++; if ({in_addr, w_addr} !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h/%h exp 0/0", in_addr, w_addr); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
      checks++; if (out_index !== 1'b0) begin errors++; $display("FAIL reset_out_index: got %h exp 0", out_index); end
      checks++; if ({pe_input, pe_weight} !== 64'h0) begin errors++; $display("FAIL reset_pe_drive: got %h/%h exp 0/0", pe_input, pe_weight); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_uniform();
      load_uniform(F_1, F_05);
      out_ready = 1'b1;
      run_collect(1'b0, 0, 20);
      // each column: 4 * (1.0 * 0.5) = 2.0
      checks++; if (got_n !== 2) begin errors++; $display("FAIL uni_count: got %0d exp 2", got_n); end
      checks++; if (got_d[0] !== F_2) begin errors++; $display("FAIL uni_d0: got %h exp %h", got_d[0], F_2); end
      checks++; if (got_i[0] !== 1'b0) begin errors++; $display("FAIL uni_i0: got %h exp 0", got_i[0]); end
      checks++; if (got_d[1] !== F_2) begin errors++; $display("FAIL uni_d1: got %h exp %h", got_d[1], F_2); end
      checks++; if (got_i[1] !== 1'b1) begin errors++; $display("FAIL uni_i1: got %h exp 1", got_i[1]); end
      checks++; if (done_at !== 15) begin errors++; $display("FAIL uni_done_at: got %0d exp 15", done_at); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL uni_done_cnt: got %0d exp 1", done_cnt); end
      checks++; if (snap_newcol[1] !== 1'b1) begin errors++; $display("FAIL uni_newcol_c0: got %b exp 1", snap_newcol[1]); end
      checks++; if (snap_newcol[2] !== 1'b0) begin errors++; $display("FAIL uni_newcol_mac: got %b exp 0", snap_newcol[2]); end
      checks++; if (snap_newcol[8] !== 1'b1) begin errors++; $display("FAIL uni_newcol_c1: got %b exp 1", snap_newcol[8]); end
      checks++; if (snap_w[8] !== 3'd4) begin errors++; $display("FAIL uni_w_base_c1: got %0d exp 4", snap_w[8]); end
      checks++; if (snap_in[2] !== 2'd1) begin errors++; $display("FAIL uni_in_addr_mac0: got %0d exp 1", snap_in[2]); end
      checks++; if (snap_w[11] !== 3'd7) begin errors++; $display("FAIL uni_w_addr_c1: got %0d exp 7", snap_w[11]); end
      checks++; if (snap_valid[7] !== 1'b1) begin errors++; $display("FAIL uni_valid_c7: got %b exp 1", snap_valid[7]); end
      checks++; if (snap_busy[1] !== 1'b1) begin errors++; $display("FAIL uni_busy_start: got %b exp 1", snap_busy[1]); end
      checks++; if (snap_busy[15] !== 1'b1) begin errors++; $display("FAIL uni_busy_done: got %b exp 1", snap_busy[15]); end
      checks++; if (snap_busy[16] !== 1'b0) begin errors++; $display("FAIL uni_busy_after: got %b exp 0", snap_busy[16]); end
   endtask

   task automatic test_relu();
      logic [31:0] iv [0:3];
      logic [31:0] wv [0:7];
      iv = '{F_1, F_1, F_1, F_1};
      wv = '{F_M1, F_M1, F_M1, F_M1, F_1, F_1, F_1, F_1};
      load_mems(iv, wv);
      run_collect(1'b1, 0, 20);
      checks++; if (got_d[0] !== F_0) begin errors++; $display("FAIL relu_on_d0: got %h exp %h", got_d[0], F_0); end
      checks++; if (got_d[1] !== F_4) begin errors++; $display("FAIL relu_on_d1: got %h exp %h", got_d[1], F_4); end
      checks++; if (got_i[1] !== 1'b1) begin errors++; $display("FAIL relu_on_i1: got %h exp 1", got_i[1]); end
      run_collect(1'b0, 0, 20);
      checks++; if (got_d[0] !== F_M4) begin errors++; $display("FAIL relu_off_d0: got %h exp %h", got_d[0], F_M4); end
      checks++; if (got_d[1] !== F_4) begin errors++; $display("FAIL relu_off_d1: got %h exp %h", got_d[1], F_4); end
   endtask

   task automatic test_distinct();
      logic [31:0] iv [0:3];
      logic [31:0] wv [0:7];
      iv = '{F_1, F_2, F_3, F_4};
      wv = '{F_2, F_3, F_4, F_5, F_1, F_0, F_0, F_0};
      load_mems(iv, wv);
      run_collect(1'b1, 0, 20);
      // col0: 1*2 + 2*3 + 3*4 + 4*5 = 40.0; col1: 1*1 = 1.0 only if cleared
      checks++; if (got_d[0] !== F_40) begin errors++; $display("FAIL dist_d0: got %h exp %h", got_d[0], F_40); end
      checks++; if (got_d[1] !== F_1) begin errors++; $display("FAIL dist_d1: got %h exp %h", got_d[1], F_1); end
   endtask

   task automatic test_stall();
      int c;
      load_uniform(F_1, F_05);
      out_ready = 1'b0;
      got_n = 0; done_cnt = 0;
      @(negedge clk);
      start = 1'b1; relu_en = 1'b0;
      c = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         c++;
      end while (!out_valid && c < 50);
      checks++; if (c !== 7) begin errors++; $display("FAIL stall_first_valid: got cycle %0d exp 7", c); end
      for (int j = 0; j <= 10; j++) begin
         if (j > 0) @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b exp 1", j, out_valid); end
         checks++; if (out_data !== F_2) begin errors++; $display("FAIL stall_data[%0d]: got %h exp %h", j, out_data, F_2); end
         checks++; if (out_index !== 1'b0) begin errors++; $display("FAIL stall_index[%0d]: got %h exp 0", j, out_index); end
         checks++; if ({in_addr, w_addr} !== {2'd3, 3'd3}) begin errors++; $display("FAIL stall_addr[%0d]: got %0d/%0d exp 3/3", j, in_addr, w_addr); end
         checks++; if (pe_result !== F_2) begin errors++; $display("FAIL stall_pe[%0d]: got %h exp %h", j, pe_result, F_2); end
      end
      out_ready = 1'b1;
      got_d[0] = 'x; got_i[0] = 'x;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (out_valid && got_n == 0) begin got_d[0] = out_data; got_i[0] = out_index; got_n++; end
         if (done) done_cnt++;
      end
      checks++; if (got_d[0] !== F_2) begin errors++; $display("FAIL stall_resume_d1: got %h exp %h", got_d[0], F_2); end
      checks++; if (got_i[0] !== 1'b1) begin errors++; $display("FAIL stall_resume_i1: got %h exp 1", got_i[0]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_cnt: got %0d exp 1", done_cnt); end
   endtask

   task automatic test_start_ignored();
      load_uniform(F_1, F_05);
      out_ready = 1'b1;
      run_collect(1'b0, 3, 40);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d exp 1", done_cnt); end
      checks++; if (done_at !== 15) begin errors++; $display("FAIL ign_done_at: got %0d exp 15", done_at); end
      checks++; if (got_d[1] !== F_2) begin errors++; $display("FAIL ign_d1: got %h exp %h", got_d[1], F_2); end
      checks++; if (snap_busy[20] !== 1'b0) begin errors++; $display("FAIL ign_busy_idle: got %b exp 0", snap_busy[20]); end
   endtask

   task automatic test_midrun_reset();
      load_uniform(F_1, F_05);
      out_ready = 1'b1;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1; relu_en = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      // second MAC cycle of col1: term 1 on the bus, term 2 addressed
      checks++; if ({in_addr, w_addr} !== {2'd2, 3'd6}) begin errors++; $display("FAIL mrst_pre_addr: got %0d/%0d exp 2/6", in_addr, w_addr); end
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, done, out_valid, pe_start_newcol} !== 4'b0) begin errors++; $display("FAIL mrst_flags: got %b exp 0000", {busy, done, out_valid, pe_start_newcol}); end
      checks++; if ({in_addr, w_addr, out_index} !== 6'd0) begin errors++; $display("FAIL mrst_addr_idx: got %0d/%0d/%0d exp 0/0/0", in_addr, w_addr, out_index); end
      checks++; if ({out_data, pe_input, pe_weight} !== 96'h0) begin errors++; $display("FAIL mrst_data: got %h/%h/%h exp 0", out_data, pe_input, pe_weight); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      checks++; if ({busy, done_cnt} !== {1'b0, 32'd0}) begin errors++; $display("FAIL mrst_idle: got busy=%b dones=%0d exp 0/0", busy, done_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
      run_collect(1'b0, 0, 20);
      checks++; if (got_d[0] !== F_2) begin errors++; $display("FAIL mrst_rerun_d0: got %h exp %h", got_d[0], F_2); end
      checks++; if (got_d[1] !== F_2) begin errors++; $display("FAIL mrst_rerun_d1: got %h exp %h", got_d[1], F_2); end
      checks++; if (done_at !== 15) begin errors++; $display("FAIL mrst_rerun_done_at: got %0d exp 15", done_at); end
   endtask

   initial begin
      load_uniform(F_0, F_0);
      test_reset();
      test_uniform();
      test_relu();
      test_distinct();
      test_stall();
      test_start_ignored();
      test_midrun_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
